// File: rtl/codec_frame_buffer.sv
// rtl/codec_frame_buffer.sv - stereo source selector packing samples into ping-pong frames for the spectrum reader
module codec_frame_buffer #(
  parameter int DATA_BITS = 16,
  parameter int ADDR_BITS = 10,
  parameter int DROP_BITS = 16
) (
  input  logic                 mclk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [DATA_BITS-1:0] sample_data_L_i,
  input  logic [DATA_BITS-1:0] sample_data_R_i,
  input  logic                 data_ready_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 frame_valid_o,
  output logic                 frame_start_o,
  input  logic                 frame_ack_i,
  output logic                 rd_bank_o,
  output logic [1:0]           frame_mode_o,
  output logic                 overflow_o,
  output logic [DROP_BITS-1:0] drop_cnt_o,
  input  logic                 clear_ovf_i
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_WAIT = 2'd2
  } wstate_t;

  wstate_t              state_q, state_d;
  logic                 wbank_q, wbank_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [1:0]           full_q, full_d;
  logic                 rd_bank_d;
  logic [1:0][1:0]      mode_q;
  logic [1:0]           wmode_q;
  logic [DATA_BITS-1:0] mem [2*DEPTH];

  logic                 ack_take;
  logic                 wr_en;
  logic                 drop;
  logic                 valid_d;

  logic [1:0]           sel_mode;
  logic [DATA_BITS:0]   l_ext, r_ext, sum, diff;
  logic [DATA_BITS-1:0] sel_sample;

  // The first sample of a frame decides the frame's mode; later samples follow it.
  assign sel_mode = (waddr_q == '0) ? mode_i : wmode_q;
  assign l_ext    = {sample_data_L_i[DATA_BITS-1], sample_data_L_i};
  assign r_ext    = {sample_data_R_i[DATA_BITS-1], sample_data_R_i};
  assign sum      = l_ext + r_ext;
  assign diff     = l_ext - r_ext;

  always_comb begin
    sel_sample = sample_data_L_i;
    case (sel_mode)
      2'b01:   sel_sample = sample_data_R_i;
      2'b10:   sel_sample = DATA_BITS'(sum >> 1);
      2'b11:   sel_sample = DATA_BITS'(diff >> 1);
      default: sel_sample = sample_data_L_i;
    endcase
  end

  assign ack_take     = frame_ack_i & frame_valid_o;
  assign wr_en        = (state_q == W_FILL) & enable_i & data_ready_i;
  assign drop         = (state_q == W_WAIT) & enable_i & data_ready_i;
  assign frame_mode_o = mode_q[rd_bank_o];

  // Ack is applied to full_d first so the writer sees a bank freed in the same cycle.
  always_comb begin
    state_d   = state_q;
    wbank_d   = wbank_q;
    waddr_d   = waddr_q;
    full_d    = full_q;
    rd_bank_d = rd_bank_o;
    if (ack_take) begin
      full_d[rd_bank_o] = 1'b0;
      rd_bank_d         = ~rd_bank_o;
    end
    if (!enable_i) begin
      state_d = W_IDLE;
      waddr_d = '0;
    end else begin
      case (state_q)
        W_IDLE: begin
          waddr_d = '0;
          if (!full_d[wbank_q]) begin
            state_d = W_FILL;
          end else if (!full_d[~wbank_q]) begin
            wbank_d = ~wbank_q;
            state_d = W_FILL;
          end else begin
            state_d = W_WAIT;
          end
        end
        W_FILL: begin
          if (data_ready_i) begin
            waddr_d = waddr_q + ADDR_BITS'(1);
            if (&waddr_q) begin
              full_d[wbank_q] = 1'b1;
              if (!full_d[~wbank_q]) wbank_d = ~wbank_q;
              else                   state_d = W_WAIT;
            end
          end
        end
        W_WAIT: begin
          waddr_d = '0;
          if (!full_d[~wbank_q]) begin
            wbank_d = ~wbank_q;
            state_d = W_FILL;
          end
        end
        default: begin
          state_d = W_IDLE;
          waddr_d = '0;
        end
      endcase
    end
  end

  // An accepted ack forces one low cycle before the next frame is offered.
  assign valid_d = full_d[rd_bank_d] & ~ack_take;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= W_IDLE;
      wbank_q       <= 1'b0;
      waddr_q       <= '0;
      full_q        <= 2'b00;
      rd_bank_o     <= 1'b0;
      frame_valid_o <= 1'b0;
      frame_start_o <= 1'b0;
      mode_q        <= '0;
      wmode_q       <= 2'b00;
      rd_data_o     <= '0;
    end else begin
      state_q       <= state_d;
      wbank_q       <= wbank_d;
      waddr_q       <= waddr_d;
      full_q        <= full_d;
      rd_bank_o     <= rd_bank_d;
      frame_valid_o <= valid_d;
      frame_start_o <= valid_d & ~frame_valid_o;
      if (wr_en && (waddr_q == '0)) begin
        mode_q[wbank_q] <= mode_i;
        wmode_q         <= mode_i;
      end
      rd_data_o <= mem[{rd_bank_o, rd_addr_i}];
    end
  end

  always_ff @(posedge mclk) begin
    if (wr_en) mem[{wbank_q, waddr_q}] <= sel_sample;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (clear_ovf_i) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (~&drop_cnt_o) drop_cnt_o <= drop_cnt_o + DROP_BITS'(1);
    end
  end

endmodule
